// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// IMEM geometry is also used by the instruction memory itself.
package imem_boot_loader_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 2 ** IMEM_ADDR_W;
  localparam int HDR_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } load_state_t;

endpackage

// File: rtl/boot_word_assembler.sv
// Big-endian byte-to-word shift register; pulses word_valid for one cycle
// after every fourth accepted byte.
module boot_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_valid,
  input  logic [7:0]  data_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      byte_idx_q <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (byte_idx_q == 2'd3);
      if (byte_valid) begin
        word       <= {word[23:0], data_byte};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, checksummed program image over a byte stream,
// writes it into instruction memory and releases the core only on success.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = HDR_CNT_W
) (
  input  logic              i_clk_w,
  input  logic              i_rst_w,
  input  logic [7:0]        i_byte_w,
  input  logic              i_valid_w,
  output logic              o_ready_w,
  output logic              o_imem_we_w,
  output logic [ADDR_W-1:0] o_imem_addr_w,
  output logic [31:0]       o_imem_wd_w,
  output logic              o_cpu_rst_n_w,
  output logic              o_done_w,
  output logic              o_error_w,
  output logic [CNT_W-1:0]  o_words_w
);

  localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   ONE_WORD  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W+2:0] ONE_BYTE  = (ADDR_W + 3)'(1);

  load_state_t       state_q, state_d;
  logic              accept, data_accept, last_byte;
  logic [7:0]        n_hi_q, csum_q;
  logic [CNT_W-1:0]  full_n;
  logic [ADDR_W:0]   n_words_q, n_words_m1, word_idx_q;
  logic [ADDR_W+2:0] data_cnt_q;
  logic              asm_valid;
  logic [31:0]       asm_word;

  assign full_n      = CNT_W'({n_hi_q, i_byte_w});
  assign accept      = i_valid_w && o_ready_w;
  assign data_accept = accept && (state_q == ST_DATA);
  assign n_words_m1  = n_words_q - ONE_WORD;
  // Byte 4N-1 of the payload is the last one: {N-1, 2'b11}.
  assign last_byte   = (data_cnt_q == {n_words_m1, 2'b11});

  always_comb begin
    state_d   = state_q;
    o_ready_w = 1'b0;
    case (state_q)
      ST_LEN_HI: begin
        o_ready_w = 1'b1;
        if (accept) state_d = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        o_ready_w = 1'b1;
        if (accept) begin
          if (full_n > MAX_WORDS)   state_d = ST_ERROR;
          else if (full_n == '0)    state_d = ST_CSUM;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        o_ready_w = 1'b1;
        if (accept && last_byte) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        o_ready_w = 1'b1;
        if (accept) state_d = (i_byte_w == csum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge i_clk_w or negedge i_rst_w) begin
    if (!i_rst_w) begin
      state_q    <= ST_LEN_HI;
      n_hi_q     <= '0;
      n_words_q  <= '0;
      csum_q     <= '0;
      data_cnt_q <= '0;
      word_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && (state_q != ST_CSUM)) csum_q <= csum_q + i_byte_w;
      if (accept && (state_q == ST_LEN_HI)) n_hi_q <= i_byte_w;
      if (accept && (state_q == ST_LEN_LO)) n_words_q <= full_n[ADDR_W:0];
      if (data_accept) data_cnt_q <= data_cnt_q + ONE_BYTE;
      if (asm_valid) word_idx_q <= word_idx_q + ONE_WORD;
    end
  end

  boot_word_assembler u_assembler (
    .clk        (i_clk_w),
    .rst_n      (i_rst_w),
    .byte_valid (data_accept),
    .data_byte  (i_byte_w),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  assign o_imem_we_w   = asm_valid;
  assign o_imem_wd_w   = asm_word;
  assign o_imem_addr_w = word_idx_q[ADDR_W-1:0];
  assign o_words_w     = CNT_W'(word_idx_q);
  assign o_done_w      = (state_q == ST_DONE);
  assign o_cpu_rst_n_w = (state_q == ST_DONE);
  assign o_error_w     = (state_q == ST_ERROR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued as
// image bytes are driven and popped when the write port pulses.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        i_valid = 1'b0;
  logic        o_ready_w, o_imem_we_w, o_cpu_rst_n_w, o_done_w, o_error_w;
  logic [5:0]  o_imem_addr_w;
  logic [31:0] o_imem_wd_w;
  logic [15:0] o_words_w;

  int compared = 0;
  int mismatched = 0;
  int writes_seen = 0;
  int stalls = 0;
  logic [37:0] sb_q[$];
  logic [31:0] img[64];

  imem_boot_loader dut (
    .i_clk_w       (clk),
    .i_rst_w       (rst_n),
    .i_byte_w      (i_byte),
    .i_valid_w     (i_valid),
    .o_ready_w     (o_ready_w),
    .o_imem_we_w   (o_imem_we_w),
    .o_imem_addr_w (o_imem_addr_w),
    .o_imem_wd_w   (o_imem_wd_w),
    .o_cpu_rst_n_w (o_cpu_rst_n_w),
    .o_done_w      (o_done_w),
    .o_error_w     (o_error_w),
    .o_words_w     (o_words_w)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every pulse must match the oldest queued write, and
  // the core may only leave reset once the queue has drained.
  always @(negedge clk) begin
    logic [37:0] exp_w;
    if (rst_n && o_imem_we_w) begin
      writes_seen++;
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_write: addr=%0d data=%08h, required no write", o_imem_addr_w, o_imem_wd_w);
      end else begin
        exp_w = sb_q.pop_front();
        if ({o_imem_addr_w, o_imem_wd_w} !== exp_w) begin
          mismatched++;
          $display("[TB] FAIL write: got addr=%0d data=%08h, required addr=%0d data=%08h",
                   o_imem_addr_w, o_imem_wd_w, exp_w[37:32], exp_w[31:0]);
        end
      end
    end
    if (rst_n && o_cpu_rst_n_w) begin
      compared++;
      if (sb_q.size() != 0) begin
        mismatched++;
        $display("[TB] FAIL early_release: cpu_rst_n=1 with %0d writes pending, required 0 pending", sb_q.size());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    if (gap > 0) begin
      i_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    i_byte  = b;
    i_valid = 1'b1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (o_ready_w) begin
        @(posedge clk);
        #1;
        return;
      end
      stalls++;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL accept_timeout: byte %02h not accepted, required acceptance within 8 cycles", b);
    i_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  task automatic send_image(input int n, input int max_gap, input bit corrupt);
    logic [7:0]  sum;
    logic [15:0] nn;
    logic [5:0]  a;
    sum = 8'h00;
    nn  = 16'(n);
    sum = sum + nn[15:8];
    send_byte(nn[15:8], pick_gap(max_gap));
    sum = sum + nn[7:0];
    send_byte(nn[7:0], pick_gap(max_gap));
    if (n > 64) begin
      i_valid = 1'b0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      a = 6'(i);
      sb_q.push_back({a, img[i]});
      for (int k = 0; k < 4; k++) begin
        sum = sum + img[i][31-8*k -: 8];
        send_byte(img[i][31-8*k -: 8], pick_gap(max_gap));
      end
    end
    send_byte(corrupt ? sum + 8'h01 : sum, pick_gap(max_gap));
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb_q.delete();
    writes_seen = 0;
    stalls      = 0;
    rst_n       = 1'b1;
  endtask

  task automatic wait_end();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_done_w || o_error_w) return;
    end
    compared++;
    mismatched++;
    $display("[TB] FAIL end_timeout: done=%b error=%b, required one of them within 60 cycles", o_done_w, o_error_w);
  endtask

  task automatic load_nominal();
    img[0] = 32'h20080005;
    img[1] = 32'hAC080000;
  endtask

  task automatic test_reset();
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #3;
    compared++;
    if ({o_imem_we_w, o_cpu_rst_n_w, o_done_w, o_error_w} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: we/rst_n/done/err=%b, required 0000",
               {o_imem_we_w, o_cpu_rst_n_w, o_done_w, o_error_w});
    end
    compared++;
    if ({o_imem_addr_w, o_imem_wd_w, o_words_w} !== 54'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: addr=%0d wd=%08h words=%0d, required all 0",
               o_imem_addr_w, o_imem_wd_w, o_words_w);
    end
    do_reset();
  endtask

  task automatic test_nominal(input int max_gap, input string tag);
    do_reset();
    load_nominal();
    send_image(2, max_gap, 1'b0);
    wait_end();
    compared++;
    if (o_done_w !== 1'b1 || o_cpu_rst_n_w !== 1'b1 || o_error_w !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_done: done=%b rst_n=%b err=%b, required 1 1 0", tag, o_done_w, o_cpu_rst_n_w, o_error_w);
    end
    compared++;
    if (o_words_w !== 16'd2 || writes_seen != 2 || sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL %s_count: words=%0d writes=%0d pending=%0d, required 2 2 0", tag, o_words_w, writes_seen, sb_q.size());
    end
    compared++;
    if (o_ready_w !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_ready: ready=%b, required 0", tag, o_ready_w);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_nominal();
    send_image(2, 0, 1'b1);
    wait_end();
    repeat (3) @(negedge clk);
    compared++;
    if (o_error_w !== 1'b1 || o_cpu_rst_n_w !== 1'b0 || o_ready_w !== 1'b0 || o_done_w !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bad_csum_flags: err=%b rst_n=%b ready=%b done=%b, required 1 0 0 0",
               o_error_w, o_cpu_rst_n_w, o_ready_w, o_done_w);
    end
    compared++;
    if (writes_seen != 2 || sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL bad_csum_writes: writes=%0d pending=%0d, required 2 0", writes_seen, sb_q.size());
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_image(65, 0, 1'b0);
    compared++;
    if (o_error_w !== 1'b1 || o_ready_w !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL oversize_error: err=%b ready=%b, required 1 0", o_error_w, o_ready_w);
    end
    i_byte  = 8'hA5;
    i_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    i_valid = 1'b0;
    compared++;
    if (writes_seen != 0 || o_cpu_rst_n_w !== 1'b0 || o_words_w !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL oversize_writes: writes=%0d rst_n=%b words=%0d, required 0 0 0",
               writes_seen, o_cpu_rst_n_w, o_words_w);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) img[i] = $urandom;
    send_image(64, 0, 1'b0);
    wait_end();
    compared++;
    if (o_done_w !== 1'b1 || o_words_w !== 16'd64 || writes_seen != 64 || sb_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL full: done=%b words=%0d writes=%0d pending=%0d, required 1 64 64 0",
               o_done_w, o_words_w, writes_seen, sb_q.size());
    end
    compared++;
    if (stalls != 0) begin
      mismatched++;
      $display("[TB] FAIL full_stalls: stalls=%0d, required 0", stalls);
    end
  endtask

  task automatic test_empty();
    do_reset();
    send_image(0, 0, 1'b0);
    wait_end();
    compared++;
    if (o_done_w !== 1'b1 || o_cpu_rst_n_w !== 1'b1 || o_words_w !== 16'd0 || writes_seen != 0) begin
      mismatched++;
      $display("[TB] FAIL empty: done=%b rst_n=%b words=%0d writes=%0d, required 1 1 0 0",
               o_done_w, o_cpu_rst_n_w, o_words_w, writes_seen);
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] a;
    do_reset();
    load_nominal();
    a = 6'd0;
    sb_q.push_back({a, img[0]});
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int k = 0; k < 4; k++) send_byte(img[0][31-8*k -: 8], 0);
    for (int k = 0; k < 2; k++) send_byte(img[1][31-8*k -: 8], 0);
    i_valid = 1'b0;
    compared++;
    if (o_words_w !== 16'd1 || writes_seen != 1) begin
      mismatched++;
      $display("[TB] FAIL mid_partial: words=%0d writes=%0d, required 1 1", o_words_w, writes_seen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (o_words_w !== 16'd0 || o_imem_we_w !== 1'b0 || o_imem_wd_w !== 32'd0 || o_imem_addr_w !== 6'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_clear: words=%0d we=%b wd=%08h addr=%0d, required all 0",
               o_words_w, o_imem_we_w, o_imem_wd_w, o_imem_addr_w);
    end
    test_nominal(0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_bad_checksum();
    test_oversize();
    test_full();
    test_empty();
    test_nominal(3, "gapped");
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
